// File: rtl/hpc3_rand_gen_pkg.sv
// Shared constants, sizing helpers and state encoding for the HPC3 masking
// randomness generator.
package hpc3_rand_gen_pkg;

  localparam int RAND_SEED_WIDTH  = 32;
  localparam int RAND_LFSR_WIDTH  = 64;
  localparam int RAND_LFSR_UNROLL = 8;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } rand_state_t;

  // One fresh random element per unordered pair of shares.
  function automatic int num_quad(input int num_shares);
    return num_shares * (num_shares - 1) / 2;
  endfunction

  function automatic int num_lfsr(input int num_shares, input int bit_width);
    return (2 * num_quad(num_shares) * bit_width + RAND_LFSR_UNROLL - 1) / RAND_LFSR_UNROLL;
  endfunction

  function automatic int num_seed_words(input int num_shares, input int bit_width);
    return num_lfsr(num_shares, bit_width) * RAND_LFSR_WIDTH / RAND_SEED_WIDTH;
  endfunction

endpackage

// File: rtl/lfsr64_unroll.sv
// Eight steps of the x^64+x^63+x^61+x^60+1 Fibonacci LFSR in one cycle.
// The first generated bit lands in bits[0].
module lfsr64_unroll
  import hpc3_rand_gen_pkg::*;
(
  input  logic [RAND_LFSR_WIDTH-1:0]  state,
  output logic [RAND_LFSR_WIDTH-1:0]  next_state,
  output logic [RAND_LFSR_UNROLL-1:0] bits
);

  logic [RAND_LFSR_WIDTH-1:0] s;
  logic                       fb;

  always_comb begin
    s    = state;
    fb   = 1'b0;
    bits = '0;
    for (int k = 0; k < RAND_LFSR_UNROLL; k++) begin
      fb      = s[63] ^ s[62] ^ s[60] ^ s[59];
      bits[k] = fb;
      s       = {s[62:0], fb};
    end
    next_state = s;
  end

endmodule

// File: rtl/hpc3_rand_gen.sv
// Reseedable LFSR bank producing registered R/P masking randomness for the
// HPC3 multipliers; seeded word-by-word, then warmed up before use.
module hpc3_rand_gen
  import hpc3_rand_gen_pkg::*;
#(
  parameter int NUM_SHARES    = 2,
  parameter int BIT_WIDTH     = 2,
  parameter int WARMUP_CYCLES = 16
) (
  input  logic                                       in_clock,
  input  logic                                       in_reset,
  input  logic [RAND_SEED_WIDTH-1:0]                 in_seed,
  input  logic                                       in_seed_valid,
  output logic                                       out_seed_ready,
  input  logic                                       in_reseed,
  input  logic                                       in_enable,
  output logic [num_quad(NUM_SHARES)*BIT_WIDTH-1:0]  out_r,
  output logic [num_quad(NUM_SHARES)*BIT_WIDTH-1:0]  out_p,
  output logic                                       out_valid,
  output logic [1:0]                                 dbg_state
);

  localparam int NUM_QUAD   = num_quad(NUM_SHARES);
  localparam int HALF_BITS  = NUM_QUAD * BIT_WIDTH;
  localparam int OUT_BITS   = 2 * HALF_BITS;
  localparam int NUM_LFSR   = num_lfsr(NUM_SHARES, BIT_WIDTH);
  localparam int SEED_WORDS = num_seed_words(NUM_SHARES, BIT_WIDTH);
  localparam int BANK_BITS  = NUM_LFSR * RAND_LFSR_WIDTH;
  localparam int GEN_BITS   = NUM_LFSR * RAND_LFSR_UNROLL;
  localparam int WCW        = $clog2(SEED_WORDS + 1);
  localparam int WUW        = $clog2(WARMUP_CYCLES + 1);

  localparam logic [WCW-1:0] LAST_WORD   = WCW'(SEED_WORDS - 1);
  localparam logic [WUW-1:0] WARMUP_INIT = WUW'(WARMUP_CYCLES);
  localparam logic [WUW-1:0] WARMUP_LAST = WUW'(1);

  rand_state_t           state;
  logic [WCW-1:0]        word_cnt;
  logic [WUW-1:0]        warm_cnt;
  logic [BANK_BITS-1:0]  bank;
  logic [BANK_BITS-1:0]  bank_next;
  logic [BANK_BITS-1:0]  bank_shift;
  logic [BANK_BITS-1:0]  bank_guarded;
  logic [GEN_BITS-1:0]   gen;
  logic                  gen_unused;

  for (genvar i = 0; i < NUM_LFSR; i++) begin : g_lfsr
    lfsr64_unroll u_lfsr (
      .state      (bank[RAND_LFSR_WIDTH*i +: RAND_LFSR_WIDTH]),
      .next_state (bank_next[RAND_LFSR_WIDTH*i +: RAND_LFSR_WIDTH]),
      .bits       (gen[RAND_LFSR_UNROLL*i +: RAND_LFSR_UNROLL])
    );
  end

  // Bits above OUT_BITS are surplus when OUT_BITS is not a multiple of 8.
  assign gen_unused = ^gen;

  // Seed words enter at the LSB end so the first word ends up in the top LFSR.
  always_comb begin
    bank_shift   = {bank[BANK_BITS-RAND_SEED_WIDTH-1:0], in_seed};
    bank_guarded = bank_shift;
    for (int i = 0; i < NUM_LFSR; i++) begin
      if (bank_shift[RAND_LFSR_WIDTH*i +: RAND_LFSR_WIDTH] == '0)
        bank_guarded[RAND_LFSR_WIDTH*i] = 1'b1;
    end
  end

  assign dbg_state = state;

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      state          <= SEED;
      word_cnt       <= '0;
      warm_cnt       <= '0;
      bank           <= '0;
      out_r          <= '0;
      out_p          <= '0;
      out_valid      <= 1'b0;
      out_seed_ready <= 1'b1;
    end else begin
      case (state)
        SEED: begin
          if (in_seed_valid && out_seed_ready) begin
            word_cnt <= word_cnt + WCW'(1);
            if (word_cnt == LAST_WORD) begin
              bank           <= bank_guarded;
              warm_cnt       <= WARMUP_INIT;
              out_seed_ready <= 1'b0;
              state          <= WARMUP;
            end else begin
              bank <= bank_shift;
            end
          end
        end
        WARMUP: begin
          bank                <= bank_next;
          {out_p, out_r}      <= gen[OUT_BITS-1:0];
          warm_cnt            <= warm_cnt - WUW'(1);
          if (warm_cnt == WARMUP_LAST) begin
            out_valid <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          // Reseed wins over a simultaneous advance; outputs are left stale.
          if (in_reseed) begin
            out_valid      <= 1'b0;
            out_seed_ready <= 1'b1;
            word_cnt       <= '0;
            state          <= SEED;
          end else if (in_enable) begin
            bank           <= bank_next;
            {out_p, out_r} <= gen[OUT_BITS-1:0];
          end
        end
        default: begin
          state <= SEED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hpc3_rand_gen.sv
// Bench for hpc3_rand_gen: default instance (2 shares, 2 bits) and a wider
// instance (3 shares, 4 bits), checked against a tap-mask LFSR model.
module tb_hpc3_rand_gen;

  localparam int W0 = 4;
  localparam int W1 = 24;
  localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [31:0]   seed0, seed1;
  logic          seed_valid0, seed_valid1, seed_ready0, seed_ready1;
  logic          reseed0, reseed1, enable0, enable1, valid0, valid1;
  logic [1:0]    r0, p0, st0, st1;
  logic [11:0]   r1, p1;

  hpc3_rand_gen dut0 (
    .in_clock(clk), .in_reset(rst_n), .in_seed(seed0), .in_seed_valid(seed_valid0),
    .out_seed_ready(seed_ready0), .in_reseed(reseed0), .in_enable(enable0),
    .out_r(r0), .out_p(p0), .out_valid(valid0), .dbg_state(st0)
  );

  hpc3_rand_gen #(.NUM_SHARES(3), .BIT_WIDTH(4), .WARMUP_CYCLES(16)) dut1 (
    .in_clock(clk), .in_reset(rst_n), .in_seed(seed1), .in_seed_valid(seed_valid1),
    .out_seed_ready(seed_ready1), .in_reseed(reseed1), .in_enable(enable1),
    .out_r(r1), .out_p(p1), .out_valid(valid1), .dbg_state(st1)
  );

  logic [W0-1:0] exp_q0[$];
  logic [W1-1:0] exp_q1[$];
  logic [W0-1:0] last0;
  logic [W1-1:0] last1;
  int total = 0;
  int bad = 0;

  // Reference: each LFSR is a 64-bit value; feedback is the parity of the tap bits.
  logic [63:0] m_lfsr [2][3];
  logic [31:0] words[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] model_adv(input int m);
    logic [23:0] g = '0;
    logic [63:0] s;
    logic b;
    int n = (m == 0) ? 1 : 3;
    for (int i = 0; i < n; i++) begin
      s = m_lfsr[m][i];
      for (int k = 0; k < 8; k++) begin
        b = ^(s & TAPS);
        g[8*i+k] = b;
        s = (s << 1) | {63'd0, b};
      end
      m_lfsr[m][i] = s;
    end
    return g;
  endfunction

  task automatic model_seed(input int m);
    logic [191:0] big = '0;
    int n = (m == 0) ? 1 : 3;
    foreach (words[j]) big = (big << 32) | {160'd0, words[j]};
    for (int i = 0; i < n; i++) begin
      m_lfsr[m][i] = big[64*i +: 64];
      if (m_lfsr[m][i] == 64'd0) m_lfsr[m][i] = 64'd1;
    end
  endtask

  // Drivers start and end 2 time units after a rising edge.
  task automatic drive_seed(input int m, input logic [31:0] w);
    int n = 0;
    if (m == 0) begin seed0 = w; seed_valid0 = 1'b1; end
    else begin seed1 = w; seed_valid1 = 1'b1; end
    @(negedge clk);
    while (!((m == 0) ? seed_ready0 : seed_ready1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("seed_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #2;
    seed_valid0 = 1'b0;
    seed_valid1 = 1'b0;
  endtask

  task automatic seed_and_warm(input int m);
    logic [23:0] g = '0;
    int e;
    foreach (words[j]) drive_seed(m, words[j]);
    model_seed(m);
    if (m == 0) check("seed_state", dut0.bank, m_lfsr[0][0]);
    for (int k = 0; k < 16; k++) g = model_adv(m);
    if (m == 0) exp_q0.push_back(g[W0-1:0]);
    else exp_q1.push_back(g[W1-1:0]);
    e = 0;
    @(negedge clk);
    while (!((m == 0) ? valid0 : valid1) && e < 40) begin
      @(negedge clk);
      e++;
    end
    check("warmup_edges", 64'(e), 64'd16);
    @(posedge clk);
    #2;
  endtask

  task automatic step(input int m, input bit en);
    logic [23:0] g;
    if (en) begin
      g = model_adv(m);
      if (m == 0) exp_q0.push_back(g[W0-1:0]);
      else exp_q1.push_back(g[W1-1:0]);
    end
    if (m == 0) enable0 = en; else enable1 = en;
    @(posedge clk);
    #2;
    enable0 = 1'b0;
    enable1 = 1'b0;
  endtask

  // Monitor: a new value is due when valid rises or after an accepted advance;
  // otherwise a valid output must hold the previous value.
  logic pv0 = 1'b0, pa0 = 1'b0, pv1 = 1'b0, pa1 = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv0 = 1'b0; pa0 = 1'b0; pv1 = 1'b0; pa1 = 1'b0;
    end else begin
      if (valid0 && (pa0 || !pv0)) begin
        if (exp_q0.size() == 0) check("sb0_unexpected_output", 64'd1, 64'd0);
        else begin
          last0 = exp_q0.pop_front();
          check("out0", 64'({p0, r0}), 64'(last0));
        end
      end else if (valid0 && pv0) check("hold0", 64'({p0, r0}), 64'(last0));
      if (valid1 && (pa1 || !pv1)) begin
        if (exp_q1.size() == 0) check("sb1_unexpected_output", 64'd1, 64'd0);
        else begin
          last1 = exp_q1.pop_front();
          check("out1", 64'({p1, r1}), 64'(last1));
        end
      end else if (valid1 && pv1) check("hold1", 64'({p1, r1}), 64'(last1));
      pv0 = valid0; pa0 = valid0 && enable0 && !reseed0;
      pv1 = valid1; pa1 = valid1 && enable1 && !reseed1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int nz;
    rst_n = 1'b0;
    seed0 = '0; seed1 = '0; seed_valid0 = 1'b0; seed_valid1 = 1'b0;
    reseed0 = 1'b0; reseed1 = 1'b0; enable0 = 1'b0; enable1 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_valid", 64'(valid0), 64'd0);
    check("reset_ready", 64'(seed_ready0), 64'd1);
    check("reset_out", 64'({p0, r0}), 64'd0);
    check("reset_state", 64'(st0), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    words = '{32'h0123_4567, 32'h89AB_CDEF};
    seed_and_warm(0);
    for (int i = 0; i < 30; i++) step(0, 1'($urandom_range(0, 1)));

    for (int i = 0; i < 10; i++) step(0, 1'b0);
    step(0, 1'b1);
    step(0, 1'b0);

    // Reseed together with enable: no advance, stale outputs kept.
    reseed0 = 1'b1;
    enable0 = 1'b1;
    @(posedge clk);
    #2;
    reseed0 = 1'b0;
    enable0 = 1'b0;
    check("reseed_valid", 64'(valid0), 64'd0);
    check("reseed_ready", 64'(seed_ready0), 64'd1);
    check("reseed_out_kept", 64'({p0, r0}), 64'(last0));
    check("reseed_state", 64'(st0), 64'd0);
    words = '{$urandom(), $urandom()};
    seed_and_warm(0);
    for (int i = 0; i < 20; i++) step(0, 1'($urandom_range(0, 1)));

    // Asynchronous reset mid-run: outputs clear before any clock edge.
    check("queue0_drained", 64'(exp_q0.size()), 64'd0);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_valid", 64'(valid0), 64'd0);
    check("async_reset_ready", 64'(seed_ready0), 64'd1);
    check("async_reset_out", 64'({p0, r0}), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Reset after a partial seed, then a clean seeding.
    drive_seed(0, $urandom());
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #2;
    words = '{$urandom(), $urandom()};
    seed_and_warm(0);
    for (int i = 0; i < 10; i++) step(0, 1'b1);

    // All-zero seed.
    reseed0 = 1'b1;
    @(posedge clk);
    #2 reseed0 = 1'b0;
    words = '{32'h0, 32'h0};
    foreach (words[j]) drive_seed(0, words[j]);
    check("zero_guard_state", dut0.bank, 64'd1);
    model_seed(0);
    begin
      logic [23:0] g = '0;
      for (int k = 0; k < 16; k++) g = model_adv(0);
      exp_q0.push_back(g[W0-1:0]);
    end
    repeat (20) @(posedge clk);
    #2;
    check("zero_guard_valid", 64'(valid0), 64'd1);
    nz = 0;
    for (int i = 0; i < 100; i++) begin
      step(0, 1'b1);
      if ({p0, r0} != '0) nz++;
    end
    check("zero_guard_nonzero", 64'(nz > 0), 64'd1);

    // Wider instance: 3 LFSRs, 6 seed words.
    words.delete();
    for (int j = 0; j < 6; j++) words.push_back($urandom());
    seed_and_warm(1);
    for (int i = 0; i < 20; i++) step(1, 1'($urandom_range(0, 1)));

    repeat (2) @(negedge clk);
    check("queue0_empty", 64'(exp_q0.size()), 64'd0);
    check("queue1_empty", 64'(exp_q1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
